// File: rtl/perf_sampler.sv
// Periodic performance-counter sampler: every period_i cycles it walks NUM_CNT
// counters starting at BASE_ADDR and streams each value out over valid/ready.
module perf_sampler #(
  parameter int         XLEN      = 64,
  parameter logic [4:0] BASE_ADDR = 5'd3,
  parameter int         NUM_CNT   = 14,
  parameter int         PERIOD_W  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                debug_mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                clear_on_read_i,
  output logic [4:0]          addr_o,
  output logic                we_o,
  output logic [XLEN-1:0]     wdata_o,
  input  logic [XLEN-1:0]     rdata_i,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic [XLEN-1:0]     sample_data_o,
  output logic [4:0]          sample_idx_o,
  output logic                sample_last_o,
  output logic [15:0]         sample_seq_o,
  output logic                busy_o,
  output logic [15:0]         overrun_cnt_o
);

  typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

  localparam logic [4:0]          LAST_IDX = 5'(NUM_CNT - 1);
  localparam logic [PERIOD_W-1:0] ONE      = PERIOD_W'(1);

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [4:0]          idx_q, idx_d;
  logic                clr_q, clr_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic [4:0]          sidx_q, sidx_d;
  logic [15:0]         seq_q, seq_d;
  logic [15:0]         ovr_q, ovr_d;
  logic                tick;

  // The timer runs independently of the FSM so mid-burst enable/debug changes
  // only affect when the next tick lands, never the burst in flight.
  always_comb begin
    tick    = 1'b0;
    timer_d = timer_q;
    if (!enable_i || period_i == '0) begin
      timer_d = '0;
    end else if (!debug_mode_i) begin
      if (timer_q >= period_i - ONE) begin
        tick    = 1'b1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_d   = clr_q;
    data_d  = data_q;
    sidx_d  = sidx_q;
    seq_d   = seq_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = READ;
          idx_d   = '0;
          clr_d   = clear_on_read_i;
        end
      end
      READ: begin
        data_d  = rdata_i;
        sidx_d  = addr_o;
        state_d = SEND;
      end
      SEND: begin
        if (sample_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            seq_d   = seq_q + 16'd1;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (tick && state_q != IDLE && ovr_q != 16'hFFFF)
      ovr_d = ovr_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      clr_q   <= 1'b0;
      data_q  <= '0;
      sidx_q  <= BASE_ADDR;
      seq_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      data_q  <= data_d;
      sidx_q  <= sidx_d;
      seq_q   <= seq_d;
      ovr_q   <= ovr_d;
    end
  end

  assign addr_o         = BASE_ADDR + idx_q;
  assign we_o           = (state_q == READ) && clr_q;
  assign wdata_o        = '0;
  assign sample_valid_o = (state_q == SEND);
  assign sample_last_o  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign sample_data_o  = data_q;
  assign sample_idx_o   = sidx_q;
  assign sample_seq_o   = seq_q;
  assign busy_o         = (state_q != IDLE);
  assign overrun_cnt_o  = ovr_q;

endmodule

// File: tb/tb_perf_sampler.sv
// Bench for perf_sampler: two instances (3 and 4 counters per burst) share
// stimulus; a burst-level model is compared every cycle, plus directed literals.
module tb_perf_sampler;
  localparam int         XLEN = 64;
  localparam logic [4:0] BASE = 5'd3;
  localparam int         NA   = 3;
  localparam int         NB   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, dbg, clr, ready;
  logic [31:0] period;

  logic [4:0]      addr  [2];
  logic            we    [2];
  logic [XLEN-1:0] wdata [2];
  logic [XLEN-1:0] rdata [2];
  logic            valid [2];
  logic [XLEN-1:0] sdata [2];
  logic [4:0]      sidx  [2];
  logic            slast [2];
  logic [15:0]     sseq  [2];
  logic            busy  [2];
  logic [15:0]     ovr   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    perf_sampler #(.XLEN(XLEN), .BASE_ADDR(BASE), .NUM_CNT(g == 0 ? NA : NB), .PERIOD_W(32)) u_dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .debug_mode_i(dbg), .period_i(period),
      .clear_on_read_i(clr), .addr_o(addr[g]), .we_o(we[g]), .wdata_o(wdata[g]),
      .rdata_i(rdata[g]), .sample_valid_o(valid[g]), .sample_ready_i(ready),
      .sample_data_o(sdata[g]), .sample_idx_o(sidx[g]), .sample_last_o(slast[g]),
      .sample_seq_o(sseq[g]), .busy_o(busy[g]), .overrun_cnt_o(ovr[g]));
  end

  // Counter store: reloaded to addr*100 whenever reset is asserted.
  logic [XLEN-1:0] mem [2][32];
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++)
        if (rst) mem[d][a] <= XLEN'(a * 100);
        else if (we[d] && addr[d] == 5'(a)) mem[d][a] <= wdata[d];
  assign rdata[0] = mem[0][addr[0]];
  assign rdata[1] = mem[1][addr[1]];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // Burst model: a burst is "sample k of n, either fetching or presenting".
  int unsigned     m_timer;
  bit              m_tick;
  bit              m_act  [2];
  int              m_k    [2];
  bit              m_pres [2];
  bit              m_clr  [2];
  int              m_seq  [2];
  int              m_ovr  [2];
  logic [XLEN-1:0] m_data [2];
  logic [XLEN-1:0] m_mem  [2][32];
  int              m_n    [2];
  initial begin m_n[0] = NA; m_n[1] = NB; end

  always @(posedge clk) begin
    m_tick = 1'b0;
    if (rst) begin
      m_timer = 0;
      for (int d = 0; d < 2; d++) begin
        m_act[d] = 0; m_k[d] = 0; m_pres[d] = 0; m_clr[d] = 0;
        m_seq[d] = 0; m_ovr[d] = 0; m_data[d] = '0;
        for (int a = 0; a < 32; a++) m_mem[d][a] = XLEN'(a * 100);
      end
    end else begin
      if (!en || period == 0) m_timer = 0;
      else if (!dbg) begin
        if (m_timer >= period - 1) begin m_tick = 1'b1; m_timer = 0; end
        else m_timer = m_timer + 1;
      end
      for (int d = 0; d < 2; d++) begin
        if (m_act[d]) begin
          if (m_tick && m_ovr[d] < 65535) m_ovr[d] = m_ovr[d] + 1;
          if (!m_pres[d]) begin
            m_data[d] = m_mem[d][int'(BASE) + m_k[d]];
            if (m_clr[d]) m_mem[d][int'(BASE) + m_k[d]] = '0;
            m_pres[d] = 1;
          end else if (ready) begin
            if (m_k[d] == m_n[d] - 1) begin
              m_act[d] = 0;
              m_seq[d] = (m_seq[d] + 1) % 65536;
            end else begin
              m_k[d] = m_k[d] + 1;
              m_pres[d] = 0;
            end
          end
        end else if (m_tick) begin
          m_act[d] = 1; m_k[d] = 0; m_pres[d] = 0; m_clr[d] = clr;
        end
      end
    end
  end

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        bit ok, e_valid, e_we;
        e_valid = m_act[d] && m_pres[d];
        e_we    = m_act[d] && !m_pres[d] && m_clr[d];
        ok = (busy[d] == m_act[d]) && (valid[d] == e_valid) && (we[d] == e_we) &&
             (wdata[d] == '0) && (ovr[d] == 16'(m_ovr[d])) && (sseq[d] == 16'(m_seq[d]));
        if (m_act[d]) ok = ok && (addr[d] == BASE + 5'(m_k[d]));
        if (e_valid)
          ok = ok && (sdata[d] == m_data[d]) && (sidx[d] == BASE + 5'(m_k[d])) &&
               (slast[d] == (m_k[d] == m_n[d] - 1));
        else
          ok = ok && (slast[d] == 1'b0);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL model%0d t=%0t busy %b/%b valid %b/%b we %b/%b ovr %0d/%0d seq %0d/%0d addr %0d k=%0d data %0d/%0d idx %0d last %b",
                      d, $time, busy[d], m_act[d], valid[d], e_valid, we[d], e_we, ovr[d], m_ovr[d],
                      sseq[d], m_seq[d], addr[d], m_k[d], sdata[d], m_data[d], sidx[d], slast[d]);
      end
    end
  end

  task automatic start(input logic [31:0] per, input logic rdy, input logic c);
    rst = 1; en = 0; dbg = 0;
    @(posedge clk); #1;
    rst = 0; period = per; ready = rdy; clr = c; en = 1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  int vcyc[$]; logic [63:0] vdat[$]; logic [4:0] vidx[$]; logic vlast[$]; logic [15:0] vseq[$];
  int          wecnt [32];
  int          n_we, n_busy, first_v, last_v, n_v;
  logic [63:0] d11, d31;
  logic [4:0]  i11, i31;
  logic        v11, v31, l31;
  logic [15:0] o31;
  bit          found;

  initial begin
    rst = 1; en = 0; dbg = 0; clr = 0; ready = 0; period = 0;
    repeat (2) @(posedge clk);
    chk_on = 1;
    #1;
    @(negedge clk);
    chk("rst_valid", valid[0], 0);  chk("rst_busy", busy[0], 0);
    chk("rst_we", we[0], 0);        chk("rst_seq", sseq[0], 0);
    chk("rst_ovr", ovr[0], 0);      chk("rst_sidx", sidx[0], BASE);
    chk("rst_data", sdata[0], 0);   chk("rst_last", slast[0], 0);
    chk("rst_addr", addr[0], BASE);

    // Basic burst with period 10, ready held high.
    start(10, 1, 0);
    n_we = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (valid[0]) begin
        vcyc.push_back(c); vdat.push_back(sdata[0]); vidx.push_back(sidx[0]);
        vlast.push_back(slast[0]); vseq.push_back(sseq[0]);
      end
      if (we[0] || we[1]) n_we++;
      nxt();
    end
    chk("b_nvalid", 64'(vcyc.size()), 4);
    if (vcyc.size() == 4) begin
      chk("b_cyc0", 64'(vcyc[0]), 11); chk("b_cyc1", 64'(vcyc[1]), 13);
      chk("b_cyc2", 64'(vcyc[2]), 15); chk("b_cyc3", 64'(vcyc[3]), 21);
      chk("b_dat0", vdat[0], 300); chk("b_dat1", vdat[1], 400); chk("b_dat2", vdat[2], 500);
      chk("b_idx0", vidx[0], 3);   chk("b_idx1", vidx[1], 4);   chk("b_idx2", vidx[2], 5);
      chk("b_last0", vlast[0], 0); chk("b_last1", vlast[1], 0); chk("b_last2", vlast[2], 1);
      chk("b_seq0", vseq[0], 0);   chk("b_seq3", vseq[3], 1);   chk("b_idx3", vidx[3], 3);
    end
    chk("b_no_we", 64'(n_we), 0);

    // Consumer stalls for 20+ cycles in SEND while ticks keep arriving.
    start(10, 0, 0);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c == 11) begin v11 = valid[0]; d11 = sdata[0]; i11 = sidx[0]; end
      if (c == 31) begin v31 = valid[0]; d31 = sdata[0]; i31 = sidx[0]; l31 = slast[0]; o31 = ovr[0]; end
      nxt();
    end
    chk("st_v11", v11, 1); chk("st_d11", d11, 300); chk("st_i11", i11, 3);
    chk("st_v31", v31, 1); chk("st_d31", d31, 300); chk("st_i31", i31, 3);
    chk("st_l31", l31, 0); chk("st_ovr", o31, 2);

    // Clear-on-read: one write per address, in the read cycle.
    start(10, 1, 1);
    for (int a = 0; a < 32; a++) wecnt[a] = 0;
    n_we = 0; first_v = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (we[0]) begin
        wecnt[addr[0]]++; n_we++;
        if (first_v < 0) first_v = c;
        if (wdata[0] != '0) chk("cr_wdata", wdata[0], 0);
      end
      nxt();
    end
    chk("cr_we3", 64'(wecnt[3]), 1); chk("cr_we4", 64'(wecnt[4]), 1);
    chk("cr_we5", 64'(wecnt[5]), 1); chk("cr_total", 64'(n_we), 3);
    chk("cr_first", 64'(first_v), 10);

    // Debug freeze delays the first tick; enable drop mid-burst must not abort.
    start(10, 1, 0);
    first_v = -1; last_v = -1; n_v = 0;
    for (int c = 0; c < 30; c++) begin
      dbg = (c >= 3 && c < 8);
      en  = !(c == 17 || c == 18);
      @(negedge clk);
      if (valid[0]) begin
        if (first_v < 0) first_v = c;
        last_v = c; n_v++;
      end
      nxt();
    end
    dbg = 0; en = 1;
    chk("dbg_first", 64'(first_v), 16); chk("dbg_last", 64'(last_v), 20);
    chk("dbg_count", 64'(n_v), 3);

    // Zero period never ticks.
    start(0, 1, 0);
    n_busy = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy[0] || busy[1]) n_busy++;
      nxt();
    end
    chk("p0_busy", 64'(n_busy), 0);

    // Short period overlaps bursts and drops ticks.
    start(4, 1, 0);
    for (int c = 0; c < 49; c++) begin
      @(negedge clk);
      if (c == 48) begin chk("ov_a", ovr[0], 6); chk("ov_b", ovr[1], 8); end
      nxt();
    end

    // Overrun saturation: tick every cycle while stuck in SEND.
    start(1, 0, 0);
    repeat (65545) @(posedge clk);
    #1;
    @(negedge clk);
    chk("sat_a", ovr[0], 16'hFFFF); chk("sat_b", ovr[1], 16'hFFFF);
    chk("sat_valid", valid[0], 1);  chk("sat_idx", sidx[0], 3);
    nxt();

    // Reset in SEND of the second sample of the second burst.
    start(10, 1, 1);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (valid[0] && sidx[0] == BASE + 5'd1 && sseq[0] == 16'd1) found = 1;
      else nxt();
    end
    chk("r_found", found, 1);
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("r_valid", valid[0], 0); chk("r_busy", busy[0], 0);
    chk("r_seq", sseq[0], 0);    chk("r_we", we[0], 0);
    nxt();
    rst = 0; en = 0;
    n_we = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (we[0] || we[1]) n_we++;
      nxt();
    end
    chk("r_no_we", 64'(n_we), 0);

    chk_on = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
